ksa: RTL
========

KSA -- requirements
Module: ksa

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port en, input, 1 bit: start request, sampled only while rdy=1.
REQ-004 SHALL have port rdy, output, 1 bit: 1 = idle and able to accept en.
REQ-005 SHALL have port key, input, 24 bits: RC4 key, 3 bytes, big-endian (key[23:16] is byte 0); latched on accept.
REQ-006 SHALL have port addr, output, 8 bits: S-memory address.
REQ-007 SHALL have port rddata, input, 8 bits: S-memory read data, valid the cycle after addr is presented with wren=0.
REQ-008 SHALL have port wrdata, output, 8 bits: S-memory write data.
REQ-009 SHALL have port wren, output, 1 bit: S-memory write enable, one write per cycle.

Function
REQ-010 SHALL perform the RC4 key-scheduling pass over the 256-byte S memory already filled by the upstream init stage: for i = 0..255, j = (j + S[i] + key[i mod 3]) mod 256, then swap S[i] and S[j]; j starts at 0.
REQ-011 SHALL perform all index and sum arithmetic in 8 bits, wrapping modulo 256 with carries discarded.
REQ-012 SHALL select key bytes with a mod-3 counter (0 -> key[23:16], 1 -> key[15:8], 2 -> key[7:0]), reset to 0 on each accept; no divider.
REQ-013 SHALL use states IDLE, RD_I, WT_I, RD_J, WT_J, WR_I, WR_J, with outputs decoded from registered state and datapath only (Moore).
REQ-014 IDLE: rdy=1, wren=0; an edge with en=1 latches key, clears i, j and the mod-3 counter, and moves to RD_I.
REQ-015 RD_I: addr=i, wren=0 -> WT_I.
REQ-016 WT_I: capture rddata as si, set j = j + rddata + keybyte -> RD_J.
REQ-017 RD_J: addr=j (new), wren=0 -> WT_J.
REQ-018 WT_J: capture rddata as sj -> WR_I.
REQ-019 WR_I: addr=i, wrdata=sj, wren=1 -> WR_J.
REQ-020 WR_J: addr=j, wrdata=si, wren=1; if i=255 go to IDLE, else increment i and mod-3 counter and go to RD_I.
REQ-021 SHALL take exactly 6 cycles per iteration; rdy SHALL fall in the cycle after the accepting edge and rise 1536 cycles after that edge.
REQ-022 SHALL ignore en while rdy=0; key changes after accept SHALL have no effect on the current run.
REQ-023 SHALL, when i=j, still issue both writes; the net result SHALL leave S[i] unchanged.
REQ-024 SHALL stop at i=255 with no wrap of i and no extra write.
REQ-025 SHALL, if en=1 in the IDLE cycle after completion, start a new pass on current memory contents, so rdy is high for exactly one cycle.
REQ-026 SHALL keep wren=0 in every state except WR_I and WR_J.

Reset
REQ-027 SHALL, on rst=1, immediately and without waiting for clk enter IDLE with rdy=1, wren=0, addr=0, wrdata=0, and i, j and the mod-3 counter at 0.
REQ-028 SHALL, on reset mid-run, issue no further writes; memory stays partially permuted and no completion is signalled.

Verification
REQ-029 Identity S (S[k]=k), key=24'h00033C, one-cycle en pulse -> rdy=0 next cycle, rdy=1 exactly 1536 cycles after accept; final S equals a software KSA model byte-for-byte.
REQ-030 Identity S, key=24'h0A0000, trace first iteration -> reads addr 0 then 0x0A; writes S[0]=0x0A then S[0x0A]=0x00.
REQ-031 Identity S, key=24'h000000 -> iteration 0 has i=j=0, writes S[0]=0x00 twice; final S matches model.
REQ-032 en pulsed and key changed at cycles 10 and 700 of a run -> no restart, same completion cycle, result matches the originally latched key.
REQ-033 rst pulsed during iteration 100 -> rdy=1 and wren=0 within the same cycle, no writes afterwards; a fresh en then completes a full 1536-cycle run.
REQ-034 en held high across completion -> rdy high for exactly one cycle, second pass begins, final S equals the model applied twice.

Source files
------------

// File: rtl/ksa.sv
// RC4 key-scheduling engine: permutes a pre-initialised 256-byte S memory
// using a 3-byte key, one read-read-write-write iteration every 6 cycles.
module ksa (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic [7:0]  addr,
  input  logic [7:0]  rddata,
  output logic [7:0]  wrdata,
  output logic        wren
);

  typedef enum logic [2:0] {
    StIdle,
    StRdI,
    StWtI,
    StRdJ,
    StWtJ,
    StWrI,
    StWrJ
  } state_e;

  state_e      state_q;
  logic [7:0]  i_q;
  logic [7:0]  j_q;
  logic [7:0]  si_q;
  logic [7:0]  sj_q;
  logic [23:0] key_q;
  logic [1:0]  kidx_q;
  logic [7:0]  key_byte;

  // kidx_q tracks i mod 3 so no divider is needed
  always_comb begin
    case (kidx_q)
      2'd0:    key_byte = key_q[23:16];
      2'd1:    key_byte = key_q[15:8];
      default: key_byte = key_q[7:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      si_q    <= 8'd0;
      sj_q    <= 8'd0;
      key_q   <= 24'd0;
      kidx_q  <= 2'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (en) begin
            key_q   <= key;
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            kidx_q  <= 2'd0;
            state_q <= StRdI;
          end
        end
        StRdI: state_q <= StWtI;
        StWtI: begin
          si_q    <= rddata;
          j_q     <= j_q + rddata + key_byte;
          state_q <= StRdJ;
        end
        StRdJ: state_q <= StWtJ;
        StWtJ: begin
          sj_q    <= rddata;
          state_q <= StWrI;
        end
        StWrI: state_q <= StWrJ;
        StWrJ: begin
          if (i_q == 8'hFF) begin
            state_q <= StIdle;
          end else begin
            i_q     <= i_q + 8'd1;
            kidx_q  <= (kidx_q == 2'd2) ? 2'd0 : kidx_q + 2'd1;
            state_q <= StRdI;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Moore decode; when i == j the second write restores S[i] to its original value
  always_comb begin
    rdy    = 1'b0;
    addr   = 8'd0;
    wrdata = 8'd0;
    wren   = 1'b0;
    case (state_q)
      StIdle: rdy = 1'b1;
      StRdI:  addr = i_q;
      StRdJ:  addr = j_q;
      StWrI: begin
        addr   = i_q;
        wrdata = sj_q;
        wren   = 1'b1;
      end
      StWrJ: begin
        addr   = j_q;
        wrdata = si_q;
        wren   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
